// File: rtl/cpu_mem_pkg.sv
// Shared types and counter widths for the CPU memory-port arbiter.
package cpu_mem_pkg;
    localparam int STARVE_W = 4;
    localparam int TIMER_W  = 8;

    typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} arb_state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants won while a fetch was waiting.
module arb_starve_ctr
    import cpu_mem_pkg::*;
#(
    parameter int W = STARVE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         at_limit
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != limit)
            cnt <= cnt + W'(1);
    end

    assign at_limit = (cnt == limit);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports,
// one outstanding transaction at a time, with starvation bound and timeout.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_read_n_write,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_read_n_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);
    arb_state_t         state, state_nx;
    owner_t             winner;
    logic [TIMER_W-1:0] timer;
    logic               dm_is_load;
    logic               any_req, grant, timeout, at_limit;
    logic               starve_inc, starve_clr;

    assign any_req = if_req | dm_req;
    assign winner  = (if_req && (!dm_req || at_limit)) ? OWN_IF : OWN_DM;
    assign grant   = (state == IDLE) && any_req && mem_gnt && !rst;
    assign timeout = (timer == TIMER_W'(TIMEOUT - 1)) && !mem_rvalid;

    // A data win only counts against the fetch if the fetch was actually waiting.
    assign starve_inc = grant && (winner == OWN_DM) && if_req;
    assign starve_clr = grant && !((winner == OWN_DM) && if_req);

    arb_starve_ctr #(.W(STARVE_W)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .limit    (STARVE_W'(STARVE_LIMIT)),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            dm_is_load <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= (state == IDLE) ? '0 : timer + TIMER_W'(1);
            if (grant && winner == OWN_DM)
                dm_is_load <= dm_read_n_write;
        end
    end

    always_comb begin
        state_nx         = state;
        if_gnt           = 1'b0;
        dm_gnt           = 1'b0;
        if_rvalid        = 1'b0;
        dm_rvalid        = 1'b0;
        if_rdata         = '0;
        dm_rdata         = '0;
        err              = 1'b0;
        mem_req          = 1'b0;
        mem_read_n_write = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    mem_req = 1'b1;
                    if (winner == OWN_IF) begin
                        mem_read_n_write = 1'b1;
                        mem_addr         = if_addr;
                        if_gnt           = mem_gnt;
                    end else begin
                        mem_read_n_write = dm_read_n_write;
                        mem_addr         = dm_addr;
                        mem_wdata        = dm_wdata;
                        dm_gnt           = mem_gnt;
                    end
                    if (mem_gnt)
                        state_nx = (winner == OWN_IF) ? WAIT_IF : WAIT_DM;
                end
            end
            WAIT_IF: begin
                if (mem_rvalid) begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                    state_nx  = IDLE;
                end else if (timeout) begin
                    if_rvalid = 1'b1;
                    err       = 1'b1;
                    state_nx  = IDLE;
                end
            end
            WAIT_DM: begin
                if (mem_rvalid) begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = dm_is_load ? mem_rdata : '0;
                    state_nx  = IDLE;
                end else if (timeout) begin
                    dm_rvalid = 1'b1;
                    err       = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Outputs are combinational; hold everything quiet while reset is asserted.
        if (rst) begin
            if_gnt           = 1'b0;
            dm_gnt           = 1'b0;
            if_rvalid        = 1'b0;
            dm_rvalid        = 1'b0;
            if_rdata         = '0;
            dm_rdata         = '0;
            err              = 1'b0;
            mem_req          = 1'b0;
            mem_read_n_write = 1'b0;
            mem_addr         = '0;
            mem_wdata        = '0;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: memory responder model plus directed scenarios.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_read_n_write, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          err, mem_req, mem_read_n_write, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_read_n_write(dm_read_n_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .err(err),
        .mem_req(mem_req), .mem_read_n_write(mem_read_n_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    bit          glog[$];
    int          gcyc[$];
    int          cyc = 0;
    int          rv_cnt = 0;
    bit          gnt_en = 1'b0;
    int          lat = 1;
    bit          drop = 1'b0;
    int          stray_cyc = -1;
    bit          pend = 1'b0;
    int          pend_cyc = 0;
    logic        pend_rnw;
    logic [31:0] pend_addr;
    logic [31:0] mem_m [logic [31:0]];
    bit          g_if;
    int          g_lat;

    assign mem_gnt = gnt_en;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Monitor and scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
        end else begin
            if (if_rvalid || dm_rvalid) begin
                rv_cnt++;
                if (sb.size() == 0) begin
                    chk("unexp_rvalid", {62'd0, if_rvalid, dm_rvalid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_cyc", cyc, e.cyc);
                    chk("rsp_if_rvalid", if_rvalid, e.is_if);
                    chk("rsp_dm_rvalid", dm_rvalid, !e.is_if);
                    chk("rsp_data", e.is_if ? if_rdata : dm_rdata, e.data);
                    chk("rsp_err", err, e.err);
                end
            end else begin
                chk("if_rdata_quiet", if_rdata, 0);
                chk("dm_rdata_quiet", dm_rdata, 0);
                chk("err_quiet", err, 0);
                if (sb.size() > 0 && cyc > sb[0].cyc) begin
                    chk("rsp_missing", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
            if (mem_req && mem_gnt) begin
                g_if = if_gnt;
                chk("gnt_onehot", if_gnt ^ dm_gnt, 1);
                if (gcyc.size() > 0) chk("gnt_spacing", (cyc - gcyc[$]) >= 2, 1);
                if (g_if) begin
                    chk("mem_addr_if", mem_addr, if_addr);
                    chk("mem_rnw_if", mem_read_n_write, 1);
                    chk("mem_wdata_if", mem_wdata, 0);
                end else begin
                    chk("mem_addr_dm", mem_addr, dm_addr);
                    chk("mem_rnw_dm", mem_read_n_write, dm_read_n_write);
                    chk("mem_wdata_dm", mem_wdata, dm_wdata);
                end
                glog.push_back(g_if);
                gcyc.push_back(cyc);
                g_lat = drop ? TO : lat;
                e.is_if = g_if;
                e.err   = drop;
                e.cyc   = cyc + g_lat;
                if (drop) e.data = 32'd0;
                else if (g_if) e.data = rd(if_addr);
                else e.data = dm_read_n_write ? rd(dm_addr) : 32'd0;
                sb.push_back(e);
                pend_rnw  = g_if ? 1'b1 : dm_read_n_write;
                pend_addr = g_if ? if_addr : dm_addr;
                if (!drop) begin
                    pend     = 1'b1;
                    pend_cyc = cyc + lat;
                end
                if (!g_if && !dm_read_n_write) mem_m[dm_addr] = dm_wdata;
            end else begin
                chk("gnt_quiet", {62'd0, if_gnt, dm_gnt}, 64'd0);
            end
        end
    end

    // Memory responder; deliberately not reset so stale responses can arrive after rst.
    always @(posedge clk) begin
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (pend && pend_cyc == cyc + 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_rnw ? rd(pend_addr) : 32'hDEAD_BEEF;
            pend       = 1'b0;
        end
        if (stray_cyc == cyc + 1) mem_rvalid = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        int target = gcyc.size() + 1;
        int b = 0;
        while (gcyc.size() < target && b < 50) begin
            tick();
            b++;
        end
        chk("wait_gnt", gcyc.size(), target);
    endtask

    task automatic wait_drain();
        int b = 0;
        while (sb.size() > 0 && b < 300) begin
            tick();
            b++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_quiet(input string tag);
        @(negedge clk);
        chk(tag, {58'd0, mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, err}, 64'd0);
        chk({tag, "_mem"}, {31'd0, mem_read_n_write, mem_addr}, 64'd0);
        chk({tag, "_data"}, {mem_wdata, if_rdata | dm_rdata}, 64'd0);
    endtask

    initial begin
        int r0, g0, st;
        rst = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_read_n_write = 0; dm_addr = 0; dm_wdata = 0;
        mem_rvalid = 0; mem_rdata = 0;
        gnt_en = 1'b1;
        tick();
        if_req = 1; dm_req = 1; dm_addr = 32'h44; dm_wdata = 32'h55;
        chk_quiet("rst_outputs");
        tick();
        if_req = 0; dm_req = 0;
        rst = 1'b0;
        tick();

        // Reset mid-transaction: the late response must be dropped.
        lat = 6; if_addr = 32'h0; if_req = 1;
        wait_gnt();
        if_req = 0;
        tick();
        rst = 1'b1;
        r0 = rv_cnt;
        chk_quiet("rst_mid_outputs");
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("rst_stale_rvalid", rv_cnt - r0, 0);

        // Fetch only, with memory initially refusing the request.
        mem_m[32'h4] = 32'h0000_FFB7;
        gnt_en = 0; lat = 2; if_addr = 32'h4; if_req = 1;
        @(negedge clk);
        chk("if_wait_mem_req", mem_req, 1);
        chk("if_wait_gnt", if_gnt, 0);
        tick();
        gnt_en = 1;
        wait_gnt();
        if_req = 0;
        wait_drain();

        // Store, then read it back.
        lat = 3; dm_read_n_write = 0; dm_addr = 32'h0000_0ABC; dm_wdata = 32'h7FFF_F000; dm_req = 1;
        wait_gnt();
        dm_req = 0;
        wait_drain();
        lat = 1; dm_read_n_write = 1; dm_wdata = 32'h1234_5678; dm_req = 1;
        wait_gnt();
        dm_req = 0;
        wait_drain();

        // Contention: fetch wins once every STARVE_LIMIT+1 grants.
        st = glog.size();
        lat = 1; if_addr = 32'h100; dm_addr = 32'h200; dm_read_n_write = 1;
        if_req = 1; dm_req = 1;
        for (int b = 0; b < 60 && glog.size() < st + 10; b++) tick();
        if_req = 0; dm_req = 0;
        wait_drain();
        chk("contention_cnt", glog.size() >= st + 10, 1);
        for (int i = 0; i < 10; i++)
            if (st + i < glog.size()) chk($sformatf("order_%0d", i), glog[st + i], (i % 5 == 4));

        // Timeout on a load; a fetch queued meanwhile is granted right after.
        drop = 1; dm_addr = 32'h300; dm_read_n_write = 1; dm_req = 1;
        wait_gnt();
        dm_req = 0; drop = 0; lat = 1;
        g0 = gcyc[$];
        if_addr = 32'h8; if_req = 1;
        wait_gnt();
        if_req = 0;
        chk("post_timeout_gnt_cyc", gcyc[$], g0 + TO + 1);
        wait_drain();

        // Response coincident with the timeout cycle is a normal response.
        lat = TO; dm_addr = 32'h400; dm_read_n_write = 1; dm_req = 1;
        wait_gnt();
        dm_req = 0;
        wait_drain();

        // Response strobe while idle.
        r0 = rv_cnt;
        stray_cyc = cyc + 3;
        repeat (6) tick();
        chk("idle_rvalid", rv_cnt - r0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
